fpu_resp_router: RTL and testbench

//  Return path of the FPU interconnect. Sits downstream of the per-cycle allocator, which maps core requests onto APUs.
//  Per APU, keeps an in-order FIFO of the core IDs whose ops that APU accepted.

---
 rtl/fpu_resp_router_if.sv | 36 +++
 rtl/fpu_resp_router.sv | 129 ++++++++++++
 tb/tb_fpu_resp_router.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_resp_router_if.sv
// Handshake/bus bundle between the allocator/APUs (master side) and the FPU response router (slave side).
interface fpu_resp_router_if #(
    parameter int NB_CORES = 4,
    parameter int NB_APUS  = 2,
    parameter int DEPTH    = 4,
    parameter int WRES     = 32,
    parameter int WFLAGS   = 5
);
    localparam int CW = $clog2(NB_CORES);
    localparam int NW = $clog2(DEPTH + 1);

    logic [NB_APUS-1:0]               issue_valid_i;
    logic [NB_APUS-1:0][CW-1:0]       issue_core_id_i;
    logic [NB_APUS-1:0]               issue_ready_o;
    logic [NB_APUS-1:0]               apu_rvalid_i;
    logic [NB_APUS-1:0][WRES-1:0]     apu_rdata_i;
    logic [NB_APUS-1:0][WFLAGS-1:0]   apu_rflags_i;
    logic [NB_APUS-1:0]               apu_rready_o;
    logic [NB_CORES-1:0]              core_rvalid_o;
    logic [NB_CORES-1:0][WRES-1:0]    core_rdata_o;
    logic [NB_CORES-1:0][WFLAGS-1:0]  core_rflags_o;
    logic [NB_APUS-1:0][NW-1:0]       outstanding_o;
    logic                             error_o;

    modport master (
        output issue_valid_i, issue_core_id_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i,
        input  issue_ready_o, apu_rready_o, core_rvalid_o, core_rdata_o, core_rflags_o,
               outstanding_o, error_o
    );

    modport slave (
        input  issue_valid_i, issue_core_id_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i,
        output issue_ready_o, apu_rready_o, core_rvalid_o, core_rdata_o, core_rflags_o,
               outstanding_o, error_o
    );
endinterface

// File: rtl/fpu_resp_router.sv
// FPU return path: per-APU in-order core-ID tag FIFOs route results to cores, 1-cycle registered output.
// Backpressure: issue_ready_o drops when a tag FIFO is full; apu_rready_o drops while an arbitration loser is held.
module fpu_resp_router #(
    parameter int NB_CORES = 4,
    parameter int NB_APUS  = 2,
    parameter int DEPTH    = 4,
    parameter int WRES     = 32,
    parameter int WFLAGS   = 5
) (
    input  logic              clk,
    input  logic              rst,
    fpu_resp_router_if.slave  bus
);
    localparam int CW = $clog2(NB_CORES);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WRES-1:0]   data;
        logic [WFLAGS-1:0] flags;
    } res_t;

    logic [CW-1:0]               tag_mem [NB_APUS][DEPTH];
    logic [NB_APUS-1:0][PW-1:0]  wr_ptr, rd_ptr;
    logic [NB_APUS-1:0][NW-1:0]  cnt;
    logic [NB_APUS-1:0]          hold_valid;
    logic [NB_APUS-1:0][CW-1:0]  hold_core;
    res_t [NB_APUS-1:0]          hold_res;
    logic [NB_CORES-1:0]         core_rvalid_q;
    res_t [NB_CORES-1:0]         core_res_q;
    logic                        error_q;

    logic [NB_APUS-1:0]          full, empty, push, accept, pop, cand_vld, win;
    logic [NB_APUS-1:0][CW-1:0]  cand_core;
    res_t [NB_APUS-1:0]          cand_res;
    logic [NB_CORES-1:0]         core_hit;
    res_t [NB_CORES-1:0]         core_sel;
    logic                        err_set;

    // Occupancy is registered, so a push into an empty FIFO can never pair with a same-cycle result.
    always_comb begin
        err_set = 1'b0;
        for (int a = 0; a < NB_APUS; a++) begin
            full[a]      = (cnt[a] == NW'(DEPTH));
            empty[a]     = (cnt[a] == '0);
            push[a]      = bus.issue_valid_i[a] & ~full[a];
            accept[a]    = bus.apu_rvalid_i[a] & ~hold_valid[a];
            pop[a]       = accept[a] & ~empty[a];
            cand_vld[a]  = hold_valid[a] | pop[a];
            cand_core[a] = hold_valid[a] ? hold_core[a] : tag_mem[a][rd_ptr[a]];
            cand_res[a]  = hold_valid[a] ? hold_res[a]
                                         : {bus.apu_rdata_i[a], bus.apu_rflags_i[a]};
            if ((bus.issue_valid_i[a] & full[a]) | (accept[a] & empty[a]))
                err_set = 1'b1;
        end
    end

    // Fixed priority: lowest-index APU wins each core.
    always_comb begin
        win      = '0;
        core_hit = '0;
        core_sel = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            for (int a = 0; a < NB_APUS; a++) begin
                if (!core_hit[c] && cand_vld[a] && cand_core[a] == CW'(c)) begin
                    core_hit[c] = 1'b1;
                    core_sel[c] = cand_res[a];
                    win[a]      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int a = 0; a < NB_APUS; a++) begin
            if (push[a])
                tag_mem[a][wr_ptr[a]] <= bus.issue_core_id_i[a];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            hold_valid    <= '0;
            hold_core     <= '0;
            hold_res      <= '0;
            core_rvalid_q <= '0;
            core_res_q    <= '0;
            error_q       <= 1'b0;
        end else begin
            for (int a = 0; a < NB_APUS; a++) begin
                if (push[a])
                    wr_ptr[a] <= wr_ptr[a] + 1'b1;
                if (pop[a])
                    rd_ptr[a] <= rd_ptr[a] + 1'b1;
                cnt[a] <= cnt[a] + NW'(push[a]) - NW'(pop[a]);
                if (hold_valid[a] && win[a]) begin
                    hold_valid[a] <= 1'b0;
                end else if (!hold_valid[a] && pop[a] && !win[a]) begin
                    hold_valid[a] <= 1'b1;
                    hold_core[a]  <= cand_core[a];
                    hold_res[a]   <= cand_res[a];
                end
            end
            // Data/flags keep their last value on cores with no winner.
            for (int c = 0; c < NB_CORES; c++) begin
                core_rvalid_q[c] <= core_hit[c];
                if (core_hit[c])
                    core_res_q[c] <= core_sel[c];
            end
            if (err_set)
                error_q <= 1'b1;
        end
    end

    always_comb begin
        bus.issue_ready_o = ~full;
        bus.apu_rready_o  = ~hold_valid;
        bus.core_rvalid_o = core_rvalid_q;
        bus.outstanding_o = cnt;
        bus.error_o       = error_q;
        for (int c = 0; c < NB_CORES; c++) begin
            bus.core_rdata_o[c]  = core_res_q[c].data;
            bus.core_rflags_o[c] = core_res_q[c].flags;
        end
    end
endmodule

// File: tb/tb_fpu_resp_router.sv
// Directed self-checking bench for fpu_resp_router; inputs change and outputs are sampled on the falling edge.
module tb_fpu_resp_router;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    fpu_resp_router_if #(.NB_CORES(4), .NB_APUS(2), .DEPTH(4), .WRES(32), .WFLAGS(5)) bus ();

    fpu_resp_router #(.NB_CORES(4), .NB_APUS(2), .DEPTH(4), .WRES(32), .WFLAGS(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.issue_valid_i   = '0;
        bus.issue_core_id_i = '0;
        bus.apu_rvalid_i    = '0;
        bus.apu_rdata_i     = '0;
        bus.apu_rflags_i    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue(input int a, input logic [1:0] core);
        bus.issue_valid_i[a]   = 1'b1;
        bus.issue_core_id_i[a] = core;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus.core_rvalid_o !== 4'b0000) begin n_fail++; $display("FAIL reset_core_rvalid: got %b exp 0000", bus.core_rvalid_o); end
        n_checks++; if (bus.outstanding_o !== 6'd0) begin n_fail++; $display("FAIL reset_outstanding: got %h exp 0", bus.outstanding_o); end
        n_checks++; if (bus.error_o !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b exp 0", bus.error_o); end
        n_checks++; if (bus.issue_ready_o !== 2'b11) begin n_fail++; $display("FAIL reset_issue_ready: got %b exp 11", bus.issue_ready_o); end
        n_checks++; if (bus.apu_rready_o !== 2'b11) begin n_fail++; $display("FAIL reset_apu_rready: got %b exp 11", bus.apu_rready_o); end
    endtask

    task automatic test_single_op();
        issue(0, 2'd2);
        n_checks++; if (bus.outstanding_o[0] !== 3'd1) begin n_fail++; $display("FAIL single_outstanding: got %0d exp 1", bus.outstanding_o[0]); end
        repeat (2) @(negedge clk);
        bus.apu_rvalid_i[0] = 1'b1;
        bus.apu_rdata_i[0]  = 32'h3F80_0000;
        bus.apu_rflags_i[0] = 5'd0;
        @(negedge clk);
        clear_inputs();
        n_checks++; if (bus.core_rvalid_o !== 4'b0100) begin n_fail++; $display("FAIL single_rvalid: got %b exp 0100", bus.core_rvalid_o); end
        n_checks++; if (bus.core_rdata_o[2] !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_rdata: got %h exp 3f800000", bus.core_rdata_o[2]); end
        n_checks++; if (bus.outstanding_o[0] !== 3'd0) begin n_fail++; $display("FAIL single_outstanding_after: got %0d exp 0", bus.outstanding_o[0]); end
        @(negedge clk);
        n_checks++; if (bus.core_rvalid_o !== 4'b0000) begin n_fail++; $display("FAIL single_pulse: got %b exp 0000", bus.core_rvalid_o); end
        n_checks++; if (bus.core_rdata_o[2] !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_data_hold: got %h exp 3f800000", bus.core_rdata_o[2]); end
    endtask

    task automatic test_in_order();
        logic [1:0]  cores [3];
        logic [31:0] dat   [3];
        logic [3:0]  onehot;
        cores = '{2'd0, 2'd3, 2'd1};
        dat   = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        for (int i = 0; i < 3; i++) issue(1, cores[i]);
        n_checks++; if (bus.outstanding_o[1] !== 3'd3) begin n_fail++; $display("FAIL inorder_outstanding3: got %0d exp 3", bus.outstanding_o[1]); end
        for (int i = 0; i < 3; i++) begin
            bus.apu_rvalid_i[1] = 1'b1;
            bus.apu_rdata_i[1]  = dat[i];
            bus.apu_rflags_i[1] = 5'(i + 1);
            @(negedge clk);
            clear_inputs();
            onehot = 4'b0001 << cores[i];
            n_checks++; if (bus.core_rvalid_o !== onehot) begin n_fail++; $display("FAIL inorder_rvalid%0d: got %b exp %b", i, bus.core_rvalid_o, onehot); end
            n_checks++; if (bus.core_rdata_o[cores[i]] !== dat[i]) begin n_fail++; $display("FAIL inorder_rdata%0d: got %h exp %h", i, bus.core_rdata_o[cores[i]], dat[i]); end
            n_checks++; if (bus.core_rflags_o[cores[i]] !== 5'(i + 1)) begin n_fail++; $display("FAIL inorder_rflags%0d: got %0d exp %0d", i, bus.core_rflags_o[cores[i]], i + 1); end
        end
        n_checks++; if (bus.outstanding_o[1] !== 3'd0) begin n_fail++; $display("FAIL inorder_outstanding0: got %0d exp 0", bus.outstanding_o[1]); end
    endtask

    task automatic test_collision();
        bus.issue_valid_i   = 2'b11;
        bus.issue_core_id_i = {2'd1, 2'd1};
        @(negedge clk);
        clear_inputs();
        bus.apu_rvalid_i = 2'b11;
        bus.apu_rdata_i  = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
        bus.apu_rflags_i = {5'd7, 5'd3};
        @(negedge clk);
        clear_inputs();
        n_checks++; if (bus.core_rvalid_o !== 4'b0010) begin n_fail++; $display("FAIL coll_rvalid1: got %b exp 0010", bus.core_rvalid_o); end
        n_checks++; if (bus.core_rdata_o[1] !== 32'hA0A0_A0A0) begin n_fail++; $display("FAIL coll_rdata1: got %h exp a0a0a0a0", bus.core_rdata_o[1]); end
        n_checks++; if (bus.apu_rready_o !== 2'b01) begin n_fail++; $display("FAIL coll_rready_held: got %b exp 01", bus.apu_rready_o); end
        @(negedge clk);
        n_checks++; if (bus.core_rvalid_o !== 4'b0010) begin n_fail++; $display("FAIL coll_rvalid2: got %b exp 0010", bus.core_rvalid_o); end
        n_checks++; if (bus.core_rdata_o[1] !== 32'hB1B1_B1B1) begin n_fail++; $display("FAIL coll_rdata2: got %h exp b1b1b1b1", bus.core_rdata_o[1]); end
        n_checks++; if (bus.core_rflags_o[1] !== 5'd7) begin n_fail++; $display("FAIL coll_rflags2: got %0d exp 7", bus.core_rflags_o[1]); end
        n_checks++; if (bus.apu_rready_o !== 2'b11) begin n_fail++; $display("FAIL coll_rready_free: got %b exp 11", bus.apu_rready_o); end
        @(negedge clk);
        n_checks++; if (bus.core_rvalid_o !== 4'b0000) begin n_fail++; $display("FAIL coll_idle: got %b exp 0000", bus.core_rvalid_o); end
        n_checks++; if (bus.outstanding_o !== 6'd0) begin n_fail++; $display("FAIL coll_outstanding: got %h exp 0", bus.outstanding_o); end
    endtask

    task automatic test_error();
        n_checks++; if (bus.error_o !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b exp 0", bus.error_o); end
        bus.apu_rvalid_i[1] = 1'b1;
        bus.apu_rdata_i[1]  = 32'hDEAD_BEEF;
        @(negedge clk);
        clear_inputs();
        n_checks++; if (bus.core_rvalid_o !== 4'b0000) begin n_fail++; $display("FAIL err_no_rvalid: got %b exp 0000", bus.core_rvalid_o); end
        n_checks++; if (bus.error_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b exp 1", bus.error_o); end
        repeat (3) @(negedge clk);
        n_checks++; if (bus.error_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b exp 1", bus.error_o); end
    endtask

    task automatic test_reset_midflight();
        issue(0, 2'd2);
        issue(0, 2'd3);
        n_checks++; if (bus.outstanding_o[0] !== 3'd2) begin n_fail++; $display("FAIL midrst_before: got %0d exp 2", bus.outstanding_o[0]); end
        do_reset();
        n_checks++; if (bus.outstanding_o !== 6'd0) begin n_fail++; $display("FAIL midrst_outstanding: got %h exp 0", bus.outstanding_o); end
        n_checks++; if (bus.error_o !== 1'b0) begin n_fail++; $display("FAIL midrst_error_clr: got %b exp 0", bus.error_o); end
        bus.apu_rvalid_i[0] = 1'b1;
        bus.apu_rdata_i[0]  = 32'h1234_5678;
        @(negedge clk);
        clear_inputs();
        n_checks++; if (bus.core_rvalid_o !== 4'b0000) begin n_fail++; $display("FAIL midrst_no_route: got %b exp 0000", bus.core_rvalid_o); end
        n_checks++; if (bus.error_o !== 1'b1) begin n_fail++; $display("FAIL midrst_error: got %b exp 1", bus.error_o); end
    endtask

    task automatic test_full();
        logic [1:0] drain [3];
        do_reset();
        for (int i = 0; i < 4; i++) issue(0, 2'(i));
        n_checks++; if (bus.outstanding_o[0] !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d exp 4", bus.outstanding_o[0]); end
        n_checks++; if (bus.issue_ready_o !== 2'b10) begin n_fail++; $display("FAIL full_ready: got %b exp 10", bus.issue_ready_o); end
        // Issue while full together with a result: ready must not see the pop.
        bus.issue_valid_i[0]   = 1'b1;
        bus.issue_core_id_i[0] = 2'd1;
        bus.apu_rvalid_i[0]    = 1'b1;
        bus.apu_rdata_i[0]     = 32'hC0DE_0000;
        #1;
        n_checks++; if (bus.issue_ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass: got %b exp 0", bus.issue_ready_o[0]); end
        n_checks++; if (bus.outstanding_o[0] !== 3'd4) begin n_fail++; $display("FAIL full_count_same_cycle: got %0d exp 4", bus.outstanding_o[0]); end
        @(negedge clk);
        clear_inputs();
        n_checks++; if (bus.core_rvalid_o !== 4'b0001) begin n_fail++; $display("FAIL full_pop_dest: got %b exp 0001", bus.core_rvalid_o); end
        n_checks++; if (bus.outstanding_o[0] !== 3'd3) begin n_fail++; $display("FAIL full_dropped_push: got %0d exp 3", bus.outstanding_o[0]); end
        n_checks++; if (bus.error_o !== 1'b1) begin n_fail++; $display("FAIL full_error: got %b exp 1", bus.error_o); end
        bus.issue_valid_i[0]   = 1'b1;
        bus.issue_core_id_i[0] = 2'd2;
        bus.apu_rvalid_i[0]    = 1'b1;
        bus.apu_rdata_i[0]     = 32'hC0DE_0001;
        @(negedge clk);
        clear_inputs();
        n_checks++; if (bus.outstanding_o[0] !== 3'd3) begin n_fail++; $display("FAIL full_push_pop_count: got %0d exp 3", bus.outstanding_o[0]); end
        n_checks++; if (bus.core_rvalid_o !== 4'b0010) begin n_fail++; $display("FAIL full_push_pop_dest: got %b exp 0010", bus.core_rvalid_o); end
        n_checks++; if (bus.issue_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL full_ready_back: got %b exp 1", bus.issue_ready_o[0]); end
        // Remaining tags: 2, 3, then the wrapped push of 2.
        drain = '{2'd2, 2'd3, 2'd2};
        for (int i = 0; i < 3; i++) begin
            bus.apu_rvalid_i[0] = 1'b1;
            bus.apu_rdata_i[0]  = 32'hD000_0000 + 32'(i);
            @(negedge clk);
            clear_inputs();
            n_checks++; if (bus.core_rvalid_o !== (4'b0001 << drain[i])) begin n_fail++; $display("FAIL full_drain%0d: got %b exp %b", i, bus.core_rvalid_o, 4'b0001 << drain[i]); end
        end
        n_checks++; if (bus.outstanding_o[0] !== 3'd0) begin n_fail++; $display("FAIL full_drained: got %0d exp 0", bus.outstanding_o[0]); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_op();
        test_in_order();
        test_collision();
        test_error();
        test_reset_midflight();
        test_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
